step_clock_gen: RTL
===================

# step_clock_gen

Single-step and auto-run clock-enable generator for the board-level processor harness. It takes the raw active-low pushbutton used for manual stepping and a run-mode switch. It produces a clean one-cycle `StepEn` pulse per confirmed press, or a periodic pulse in auto mode, and feeds that enable to the multicycle processor and the HEX/LED debug displays downstream. It also keeps a wrapping step counter for display.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable samples required to accept a press or release (20 ms at 50 MHz).
- `AUTO_DIV`, default 25_000_000: cycles between auto-mode pulses; must be ≥ 2.
- `CNT_W`, default 16: width of `StepCount`.
- `Clock  in  1`: board clock; all logic on rising edge.
- `Resetn  in  1`: reset, synchronous and active-low.
- `KeyStep  in  1`: raw pushbutton, active-low, asynchronous to `Clock`, may bounce.
- `AutoRun  in  1`: slide switch; 1 = auto mode. Asynchronous, level.
- `Halt  in  1`: synchronous; 1 suppresses all pulses (driven by processor `Done` when halt-on-done is wanted).
- `StepEn  out  1`: one-`Clock`-cycle enable pulse.
- `KeyLevel  out  1`: debounced key state, 1 = pressed.
- `StepCount  out  CNT_W`: number of `StepEn` pulses since reset, wraps.
- `DbState  out  2`: current debounce state encoding, for LED debug.

## Operation
- Input conditioning: `KeyStep` and `AutoRun` each pass through a 2-flop synchronizer. Downstream logic uses only the synchronized values `key_s` (inverted, 1 = pressed) and `auto_s`.
- Debounce FSM, counter `dcnt` (width ⌈log2(DEBOUNCE_CYCLES+1)⌉):
  - UP (00): if `key_s`=1, clear `dcnt` and go to WAIT_DOWN.
  - WAIT_DOWN (01): if `key_s`=0, go to UP (bounce rejected). Otherwise increment `dcnt`; when `dcnt` reaches DEBOUNCE_CYCLES−1, go to DOWN and raise `press_evt` for one cycle.
  - DOWN (11): if `key_s`=0, clear `dcnt` and go to WAIT_UP.
  - WAIT_UP (10): if `key_s`=1, go to DOWN. Otherwise increment `dcnt`; at DEBOUNCE_CYCLES−1 go to UP. A release never produces a pulse.
- `KeyLevel` = 1 in DOWN and WAIT_UP.
- Auto prescaler `acnt`:
  - Counts 0..AUTO_DIV−1 while `auto_s`=1.
  - `tick` is asserted when `acnt`=AUTO_DIV−1, and `acnt` wraps to 0 on that cycle.
  - Held at 0 while `auto_s`=0.
- Pulse selection:
  - Manual mode (`auto_s`=0): `StepEn_next` = `press_evt`.
  - Auto mode: `StepEn_next` = `tick`; `press_evt` is ignored (the FSM still runs).
  - `Halt`=1 forces `StepEn_next`=0; a suppressed event is dropped, not queued.
- `StepEn` is registered. `StepCount` increments by 1 in the same cycle `StepEn` is 1, and wraps from 2^CNT_W−1 to 0.

## Timing
- Reset (`Resetn`=0 at a rising edge) sets, on that edge:
  - FSM to UP, `dcnt`=0, `acnt`=0.
  - Synchronizer flops to the idle values: key flops 1 (released), auto flops 0.
  - `StepEn`=0, `KeyLevel`=0, `StepCount`=0, `DbState`=00.
- Reset mid-press or mid-count aborts all activity. The key must be seen released→pressed again after reset before any pulse occurs.
- Press latency: `KeyStep` sampled low first at edge k and held low gives `key_s`=1 after edge k+1 and WAIT_DOWN after edge k+2. `StepEn` is high for exactly the cycle following edge k+2+DEBOUNCE_CYCLES.
- A bounce (any high sample) during WAIT_DOWN restarts the full count from the next low sample.
- Auto mode: once `auto_s` rises, the first `StepEn` occurs AUTO_DIV+1 cycles later; after that, one pulse every AUTO_DIV cycles exactly.
- Switching `auto_s` to 0 mid-count clears `acnt` on the next edge with no pulse. Switching back restarts the full period.
- `tick` and `press_evt` in the same cycle: at most one pulse is ever generated. Auto mode wins.
- `StepEn` is never high on two consecutive cycles (guaranteed by AUTO_DIV ≥ 2 and the FSM structure).

## Structure
- Package `step_clock_pkg` holds:
  - debounce state typedef (`UP`, `WAIT_DOWN`, `DOWN`, `WAIT_UP` with the 2-bit encodings above);
  - the default parameter constants.
- Sub-module `key_debounce`: synchronizer plus FSM plus `dcnt`, with outputs `press_evt`, `KeyLevel` and `DbState`. It is reused for other board keys.
- Top: AutoRun synchronizer, prescaler, pulse mux, `StepEn` register and `StepCount`.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, AUTO_DIV=8, CNT_W=4.
- Reset, then clean press at edge 10 held 20 cycles → single `StepEn` in the cycle after edge 16; `StepCount`=1; no pulse on release; `KeyLevel` falls 6 cycles after release.
- Press with bounces (low 2 cycles, high 1, low 10) → exactly one `StepEn`, timed from the final low run's start.
- `AutoRun`=1 for 40 cycles → `StepEn` at cycles 9, 17, 25, 33 after the switch; manual presses during the window add nothing; `StepCount`=4.
- `Halt`=1 during an auto tick and during a confirmed press → no pulse; `StepCount` unchanged; pulses resume after `Halt`=0.
- 17 manual presses → `StepCount` sequence ends at 1 (wrap through 15→0).
- `Resetn`=0 asserted in WAIT_DOWN with `StepCount`=5 → all outputs 0 next edge; key still held low after reset produces no pulse until released and re-pressed.

Source files
------------

// File: rtl/step_clock_gen_pkg.sv
// Shared constants and debounce state encoding for the step clock generator.
package step_clock_pkg;

   localparam int DEBOUNCE_CYCLES_DEF = 1_000_000;  // 20 ms at 50 MHz
   localparam int AUTO_DIV_DEF        = 25_000_000; // 2 pulses per second at 50 MHz
   localparam int CNT_W_DEF           = 16;

   // Debounce states; bit 1 doubles as the debounced "pressed" level.
   typedef logic [1:0] db_state_t;

   localparam db_state_t UP        = 2'b00;
   localparam db_state_t WAIT_DOWN = 2'b01;
   localparam db_state_t DOWN      = 2'b11;
   localparam db_state_t WAIT_UP   = 2'b10;

endpackage

// File: rtl/step_clock_gen_if.sv
// Harness-side signals of the step clock generator: key/switch/halt in,
// step enable and debug status out.
interface step_clock_gen_if
   import step_clock_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
);
   logic             KeyStep;
   logic             AutoRun;
   logic             Halt;
   logic             StepEn;
   logic             KeyLevel;
   logic [CNT_W-1:0] StepCount;
   db_state_t        DbState;

   modport master (
      output KeyStep, AutoRun, Halt,
      input  StepEn, KeyLevel, StepCount, DbState
   );

   modport slave (
      input  KeyStep, AutoRun, Halt,
      output StepEn, KeyLevel, StepCount, DbState
   );
endinterface

// File: rtl/step_clock_gen_key_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer, press/release debounce FSM and
// a one-cycle press event. Reusable for any active-low board key.
module key_debounce
   import step_clock_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic      Clock,
   input  logic      Resetn,
   input  logic      KeyRaw,    // active-low, asynchronous, bouncy
   output logic      press_evt, // one cycle, on the last stable pressed sample
   output logic      KeyLevel,
   output db_state_t DbState
);
   localparam int            DW    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE_CYCLES - 1);

   logic [1:0]    sync_q;  // raw key, idle-high
   logic [1:0]    vld_q;   // marks when sync_q holds real samples after reset
   logic          armed_q; // a released key has been seen since reset
   logic          key_s;
   db_state_t     state_q, state_d;
   logic [DW-1:0] dcnt_q, dcnt_d;

   assign key_s = ~sync_q[1];

   // Synchronize the key and arm only once a genuine release has been observed,
   // so a key held through reset cannot generate a press.
   always_ff @(posedge Clock) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (!Resetn) begin
         sync_q  <= 2'b11;
         vld_q   <= 2'b00;
         armed_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], KeyRaw};
         vld_q  <= {vld_q[0], 1'b1};
         if (vld_q[1] && !key_s) begin
            armed_q <= 1'b1;
         end
      end
   end

   // Debounce next-state: a stable run of DEBOUNCE_CYCLES samples flips the level.
   always_comb begin
      // NOTE: every output of this block gets a default first, otherwise the
      // branches that leave it unassigned would infer latches.
      state_d   = state_q;
      dcnt_d    = dcnt_q;
      press_evt = 1'b0;
      case (state_q)
         UP: begin
            if (key_s && armed_q) begin
               dcnt_d  = '0;
               state_d = WAIT_DOWN;
            end
         end
         WAIT_DOWN: begin
            if (!key_s) begin
               state_d = UP;
            end else begin
               dcnt_d = dcnt_q + 1'b1;
               if (dcnt_q == DLAST) begin
                  state_d   = DOWN;
                  press_evt = 1'b1;
               end
            end
         end
         DOWN: begin
            if (!key_s) begin
               dcnt_d  = '0;
               state_d = WAIT_UP;
            end
         end
         WAIT_UP: begin
            if (key_s) begin
               state_d = DOWN;
            end else begin
               dcnt_d = dcnt_q + 1'b1;
               if (dcnt_q == DLAST) begin
                  state_d = UP;
               end
            end
         end
         default: state_d = UP;
      endcase
   end

   // Debounce state and counter registers.
   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         state_q <= UP;
         dcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         dcnt_q  <= dcnt_d;
      end
   end

   assign KeyLevel = state_q[1];
   assign DbState  = state_q;

endmodule

// File: rtl/step_clock_gen.sv
// Single-step / auto-run clock-enable generator for the processor harness.
module step_clock_gen
   import step_clock_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int AUTO_DIV        = AUTO_DIV_DEF,   // must be >= 2
   parameter int CNT_W           = CNT_W_DEF
) (
   input logic             Clock,
   input logic             Resetn,
   step_clock_gen_if.slave bus
);
   localparam int            AW    = $clog2(AUTO_DIV);
   localparam logic [AW-1:0] ALAST = AW'(AUTO_DIV - 1);

   logic             press_evt;
   logic [1:0]       auto_q;
   logic             auto_s;
   logic [AW-1:0]    acnt_q;
   logic             tick;
   logic             step_next;
   logic             step_q;
   logic [CNT_W-1:0] cnt_q;

   key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_key (
      .Clock    (Clock),
      .Resetn   (Resetn),
      .KeyRaw   (bus.KeyStep),
      .press_evt(press_evt),
      .KeyLevel (bus.KeyLevel),
      .DbState  (bus.DbState)
   );

   // Synchronize the run-mode switch.
   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         auto_q <= 2'b00;
      end else begin
         auto_q <= {auto_q[0], bus.AutoRun};
      end
   end

   assign auto_s = auto_q[1];
   assign tick   = auto_s && (acnt_q == ALAST);

   // Auto prescaler: free-runs 0..AUTO_DIV-1 in auto mode, parked at 0 otherwise.
   always_ff @(posedge Clock) begin
      if (!Resetn || !auto_s || tick) begin
         acnt_q <= '0;
      end else begin
         acnt_q <= acnt_q + 1'b1;
      end
   end

   // Auto mode owns the pulse source; Halt drops events rather than deferring them.
   assign step_next = !bus.Halt && (auto_s ? tick : press_evt);

   // Registered step enable with a counter that moves in the same cycle.
   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         step_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         step_q <= step_next;
         if (step_next) begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign bus.StepEn    = step_q;
   assign bus.StepCount = cnt_q;

endmodule
